// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   tx_state_e  : transmitter FSM states
//   OS16 / OS13 : sample ticks per bit for the two oversampling modes
//   FIFO_DEPTH  : default TX FIFO depth
//   WLS_BASE    : word length is WLS_BASE + WLS
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int OS16       = 16;
    localparam int OS13       = 13;
    localparam int FIFO_DEPTH = 16;
    localparam int WLS_BASE   = 5;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous character buffer for the transmitter. Runs either as a
// DEPTH-entry FIFO or, with one_deep_i set, as a single holding register.
// Ports:
//   clk_i, rstn_i   : clock, asynchronous active-low reset
//   one_deep_i      : limit capacity to one entry
//   flush_i         : empty the buffer (wins over push and pop)
//   push_i          : write push_data_i (ignored when full)
//   pop_i           : discard head entry (ignored when empty)
//   head_data_o     : entry at the head
//   level_o         : number of stored entries
//   full_o, empty_o : status
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = uart_pkg::FIFO_DEPTH,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             one_deep_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [7:0]       push_data_i,
    input  logic             pop_i,
    output logic [7:0]       head_data_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);
    import uart_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty_o     = (level_q == '0);
    assign full_o      = one_deep_i ? !empty_o : (level_q == LVL_W'(DEPTH));
    assign wr_en       = push_i && !full_o && !flush_i;
    assign rd_en       = pop_i && !empty_o && !flush_i;
    assign head_data_o = mem_q[head_q];
    assign level_o     = level_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            // Pointers wrap naturally at the power-of-two depth.
            if (wr_en) tail_d = tail_q + 1'b1;
            if (rd_en) head_d = head_q + 1'b1;
            level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[tail_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmit engine: buffers THR writes, derives the bit timing from
// DLR/OSM and serialises start, data (LSB first), optional parity and stop
// bits onto txd_out. Reports THRE/TEMT to the line status register.
// Ports:
//   apb_clk_in, apb_rstn_in : clock, asynchronous active-low reset
//   thr_data_in, thr_wr_in  : THR write data and strobe
//   fifoen_in, txclr_in     : FIFO mode select, buffer flush pulse
//   wls_in, stb_in, pen_in, eps_in, sp_in, bc_in : line control
//   dlr_in, osm_in          : baud divisor, 13x/16x oversampling select
//   utrst_in                : 0 holds the transmitter in reset
//   txd_out                 : registered serial output
//   thre_out, temt_out      : buffer empty, transmitter empty
//   tx_level_out            : buffer occupancy
//   tx_ovf_out              : pulse when a write is dropped
//   tx_dma_req_out          : DMA request (only with UART_TX_DMA_EN)
// Build option: define UART_TX_DMA_EN to add the DMA request output.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int FIFO_DEPTH = uart_pkg::FIFO_DEPTH,
    parameter int LVL_W      = 5
) (
    input  logic             apb_clk_in,
    input  logic             apb_rstn_in,
    input  logic [7:0]       thr_data_in,
    input  logic             thr_wr_in,
    input  logic             fifoen_in,
    input  logic             txclr_in,
    input  logic [1:0]       wls_in,
    input  logic             stb_in,
    input  logic             pen_in,
    input  logic             eps_in,
    input  logic             sp_in,
    input  logic             bc_in,
    input  logic [15:0]      dlr_in,
    input  logic             osm_in,
    input  logic             utrst_in,
    output logic             txd_out,
    output logic             thre_out,
    output logic             temt_out,
    output logic [LVL_W-1:0] tx_level_out,
    output logic             tx_ovf_out
`ifdef UART_TX_DMA_EN
    ,
    output logic             tx_dma_req_out
`endif
);
    import uart_pkg::*;

    tx_state_e        state_q, state_d;
    logic [15:0]      pre_q, pre_d;
    logic [15:0]      dlr_q, dlr_d;
    logic [4:0]       os_q, os_d;
    logic [4:0]       oslen_q, oslen_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [1:0]       wls_q, wls_d;
    logic             stb_q, stb_d;
    logic             pen_q, pen_d;
    logic             txd_q, txd_d;
    logic             fifoen_q;
    logic             ovf_q, ovf_d;

    logic             flush;
    logic             pop;
    logic             full;
    logic             empty;
    logic [7:0]       head_data;
    logic [LVL_W-1:0] level;
    logic             tick;
    logic             bit_end;
    logic [5:0]       bit_last;
    logic [2:0]       last_data_bit;
    logic             line;

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                        input logic eps, input logic sp);
        logic [7:0] mask;
        logic       ones_odd;
        mask     = 8'hFF >> (2'd3 - wls);
        ones_odd = ^(data & mask);
        if (sp) return !eps;
        return eps ? ones_odd : !ones_odd;
    endfunction

    function automatic logic [4:0] os_ticks(input logic osm);
        return osm ? 5'(OS13) : 5'(OS16);
    endfunction

    // Any mode change, flush pulse or transmitter reset empties the buffer.
    assign flush = txclr_in || (fifoen_in != fifoen_q) || !utrst_in;
    assign ovf_d = thr_wr_in && utrst_in && !flush && full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i       (apb_clk_in),
        .rstn_i      (apb_rstn_in),
        .one_deep_i  (!fifoen_in),
        .flush_i     (flush),
        .push_i      (thr_wr_in && utrst_in),
        .push_data_i (thr_data_in),
        .pop_i       (pop),
        .head_data_o (head_data),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty)
    );

    // A latched divisor of zero never ticks; the FSM simply waits.
    assign tick = (dlr_q != '0) && (pre_q == dlr_q - 16'd1);

    // Bit length in sample ticks; the 1.5-stop case only applies to 5-bit words.
    always_comb begin
        bit_last = 6'(oslen_q) - 6'd1;
        if (state_q == ST_STOP && stb_q) begin
            if (wls_q == 2'd0) bit_last = 6'(oslen_q) + 6'(oslen_q >> 1) - 6'd1;
            else               bit_last = (6'(oslen_q) << 1) - 6'd1;
        end
    end

    assign bit_end       = tick && (6'(os_q) == bit_last);
    assign last_data_bit = 3'(WLS_BASE - 1) + {1'b0, wls_q};

    always_comb begin
        pre_d   = pre_q;
        dlr_d   = dlr_q;
        os_d    = os_q;
        oslen_d = oslen_q;
        if (!utrst_in || state_q == ST_IDLE) begin
            pre_d   = '0;
            dlr_d   = dlr_in;
            os_d    = '0;
            oslen_d = os_ticks(osm_in);
        end else if (dlr_q == '0) begin
            dlr_d = dlr_in;
        end else if (tick) begin
            pre_d = '0;
            dlr_d = dlr_in;
            if (bit_end) begin
                os_d    = '0;
                oslen_d = os_ticks(osm_in);
            end else begin
                os_d = os_q + 5'd1;
            end
        end else begin
            pre_d = pre_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        pop     = 1'b0;
        line    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!empty && utrst_in && dlr_in != '0) begin
                    pop     = 1'b1;
                    shift_d = head_data;
                    wls_d   = wls_in;
                    stb_d   = stb_in;
                    pen_d   = pen_in;
                    par_d   = parity_bit(head_data, wls_in, eps_in, sp_in);
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == last_data_bit) state_d = pen_q ? ST_PARITY : ST_STOP;
                    else                        bit_d   = bit_q + 3'd1;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!utrst_in) begin
            state_d = ST_IDLE;
            bit_d   = '0;
        end
        // txd is registered, so it is driven from the state being entered.
        case (state_d)
            ST_START:  line = 1'b0;
            ST_DATA:   line = shift_d[0];
            ST_PARITY: line = par_d;
            default:   line = 1'b1;
        endcase
        txd_d = !utrst_in ? 1'b1 : (bc_in ? 1'b0 : line);
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            dlr_q    <= '0;
            os_q     <= '0;
            oslen_q  <= 5'(OS16);
            bit_q    <= '0;
            txd_q    <= 1'b1;
            fifoen_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            dlr_q    <= dlr_d;
            os_q     <= os_d;
            oslen_q  <= oslen_d;
            bit_q    <= bit_d;
            txd_q    <= txd_d;
            fifoen_q <= fifoen_in;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge apb_clk_in) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        wls_q   <= wls_d;
        stb_q   <= stb_d;
        pen_q   <= pen_d;
    end

    assign txd_out      = txd_q;
    assign thre_out     = empty;
    assign temt_out     = empty && (state_q == ST_IDLE);
    assign tx_level_out = level;
    assign tx_ovf_out   = ovf_q;

`ifdef UART_TX_DMA_EN
    logic dma_q, dma_d;

    assign dma_d = utrst_in && (fifoen_in ? (level <= LVL_W'(FIFO_DEPTH / 2)) : empty);

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) dma_q <= 1'b0;
        else              dma_q <= dma_d;
    end

    assign tx_dma_req_out = dma_q;
`endif

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  thr_data;
    logic        thr_wr;
    logic        fifoen;
    logic        txclr;
    logic [1:0]  wls;
    logic        stb, pen, eps, sp, bc;
    logic [15:0] dlr;
    logic        osm;
    logic        utrst;
    logic        txd, thre, temt, ovf;
    logic [4:0]  level;
`ifdef UART_TX_DMA_EN
    logic        dma;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  chars [4];
    bit          exp_q [$];

    always #5 clk = ~clk;

    uart_tx dut (
        .apb_clk_in   (clk),
        .apb_rstn_in  (rstn),
        .thr_data_in  (thr_data),
        .thr_wr_in    (thr_wr),
        .fifoen_in    (fifoen),
        .txclr_in     (txclr),
        .wls_in       (wls),
        .stb_in       (stb),
        .pen_in       (pen),
        .eps_in       (eps),
        .sp_in        (sp),
        .bc_in        (bc),
        .dlr_in       (dlr),
        .osm_in       (osm),
        .utrst_in     (utrst),
        .txd_out      (txd),
        .thre_out     (thre),
        .temt_out     (temt),
        .tx_level_out (level),
        .tx_ovf_out   (ovf)
`ifdef UART_TX_DMA_EN
        ,
        .tx_dma_req_out (dma)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference frame: per-cycle line levels derived from the line settings.
    function automatic void add_frame(input logic [7:0] d);
        int   os;
        int   bitc;
        int   nb;
        int   stopc;
        bit   p;
        os   = osm ? 13 : 16;
        bitc = int'(dlr) * os;
        nb   = 5 + int'(wls);
        repeat (bitc) exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            repeat (bitc) exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pen) begin
            if (sp)        p = ~eps;
            else if (!eps) p = ~p;
            repeat (bitc) exp_q.push_back(p);
        end
        if (!stb)         stopc = bitc;
        else if (nb == 5) stopc = (os + os / 2) * int'(dlr);
        else              stopc = 2 * bitc;
        repeat (stopc) exp_q.push_back(1'b1);
    endfunction

    // Writes k characters on consecutive cycles starting now (cycle 0) and
    // checks the line cycle by cycle. clr_at >= 0 pulses txclr at that cycle,
    // which must leave only the first frame on the line.
    task automatic send_burst(input int k, input int clr_at);
        int total;
        exp_q.delete();
        for (int i = 0; i < k; i++) begin
            add_frame(chars[i]);
            if (clr_at >= 0) break;
            if (i < k - 1) exp_q.push_back(1'b1);
        end
        total    = exp_q.size();
        thr_wr   = 1'b1;
        thr_data = chars[0];
        for (int cyc = 1; cyc <= total + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("lvl_first", level, 1);
                chk("thre_first", thre, 0);
                chk("temt_first", temt, 0);
            end
            if (cyc >= 2 && cyc < 2 + total) chk("txd", txd, exp_q[cyc-2]);
            if (cyc == 2 + total) begin
                chk("temt_end", temt, 1);
                chk("txd_end", txd, 1);
                chk("lvl_end", level, 0);
            end
            if (clr_at >= 0 && cyc == clr_at + 1) begin
                chk("lvl_clr", level, 0);
                chk("thre_clr", thre, 1);
                chk("temt_clr", temt, 0);
            end
            thr_wr = (cyc < k);
            if (cyc < k) thr_data = chars[cyc];
            txclr = (cyc == clr_at);
        end
        thr_wr = 1'b0;
        txclr  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int k;
        thr_data = '0; thr_wr = 1'b0; fifoen = 1'b1; txclr = 1'b0;
        wls = 2'd3; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; bc = 1'b0;
        dlr = 16'd1; osm = 1'b0; utrst = 1'b1;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_thre", thre, 1);
        chk("rst_temt", temt, 1);
        chk("rst_lvl", level, 0);
        chk("rst_ovf", ovf, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1, 0x55
        chars[0] = 8'h55;
        send_burst(1, -1);

        // 5E1.5, 0x07, 13x oversampling, divisor 2
        wls = 2'd0; pen = 1'b1; eps = 1'b1; sp = 1'b0; stb = 1'b1; dlr = 16'd2; osm = 1'b1;
        chars[0] = 8'h07;
        send_burst(1, -1);

        // Randomised line settings, bursts of back-to-back frames
        for (int r = 0; r < 6; r++) begin
            wls = 2'($urandom_range(0, 3));
            pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
            stb = 1'($urandom); osm = 1'($urandom);
            dlr = 16'($urandom_range(1, 3));
            k   = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) chars[i] = 8'($urandom);
            send_burst(k, -1);
        end

        // Overflow: divisor 0 stalls the transmitter, 17 writes into 16 entries
        wls = 2'd3; pen = 1'b0; stb = 1'b0; osm = 1'b0; dlr = 16'd0;
        thr_wr = 1'b1; thr_data = 8'd0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("ovf_fill", ovf, (i == 16));
            chk("txd_stall", txd, 1);
            if (i < 16) thr_data = 8'(i + 1);
            else        thr_wr = 1'b0;
        end
        @(negedge clk);
        chk("ovf_after", ovf, 0);
        chk("lvl_full", level, 16);
        chk("thre_full", thre, 0);
        chk("temt_full", temt, 0);
        txclr = 1'b1;
        @(negedge clk);
        txclr = 1'b0;
        chk("lvl_txclr", level, 0);
        chk("thre_txclr", thre, 1);

        // Holding-register mode: capacity 1
        fifoen = 1'b0;
        @(negedge clk);
        thr_wr = 1'b1; thr_data = 8'hA5;
        @(negedge clk);
        chk("ovf_1deep_a", ovf, 0);
        chk("lvl_1deep", level, 1);
        chk("thre_1deep", thre, 0);
        thr_data = 8'h5A;
        @(negedge clk);
        thr_wr = 1'b0;
        chk("ovf_1deep_b", ovf, 1);
        chk("lvl_1deep_b", level, 1);
        @(negedge clk);
        chk("ovf_1deep_c", ovf, 0);
        fifoen = 1'b1;
        @(negedge clk);
        chk("lvl_mode_chg", level, 0);

        // Flush while the first of three frames is shifting
        dlr = 16'd1;
        for (int i = 0; i < 4; i++) chars[i] = 8'($urandom);
        send_burst(3, 40);

        // Break mid-frame, then transmitter reset with a write while held
        thr_wr = 1'b1; thr_data = 8'hFF;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 30) chk("txd_prebrk", txd, 1);
            if (cyc >= 31 && cyc <= 33) chk("txd_break", txd, 0);
            if (cyc == 34) begin
                chk("txd_utrst", txd, 1);
                chk("temt_utrst", temt, 1);
                chk("lvl_utrst", level, 0);
                chk("thre_utrst", thre, 1);
            end
            if (cyc == 35) begin
                chk("ovf_utrst", ovf, 0);
                chk("lvl_utrst_wr", level, 0);
            end
            if (cyc >= 36) begin
                chk("txd_idle", txd, 1);
                chk("temt_idle", temt, 1);
            end
            thr_wr   = (cyc < 2) || (cyc == 34);
            thr_data = 8'($urandom);
            bc       = (cyc >= 30 && cyc < 35);
            utrst    = !(cyc >= 33 && cyc < 35);
        end
        thr_wr = 1'b0;

        // Asynchronous reset in the middle of a start bit
        thr_wr = 1'b1; thr_data = 8'h00;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            thr_wr = 1'b0;
        end
        chk("txd_pre_arst", txd, 0);
        #2 rstn = 1'b0;
        #1;
        chk("txd_arst", txd, 1);
        chk("temt_arst", temt, 1);
        chk("lvl_arst", level, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("txd_post_arst", txd, 1);

`ifdef UART_TX_DMA_EN
        dlr = 16'd0;
        thr_wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            thr_data = 8'(i);
            @(negedge clk);
        end
        thr_wr = 1'b0;
        repeat (2) @(negedge clk);
        chk("lvl_dma9", level, 9);
        chk("dma_lvl9", dma, 0);
        dlr = 16'd1;
        repeat (3) @(negedge clk);
        chk("lvl_dma8", level, 8);
        chk("dma_lvl8", dma, 1);
        utrst = 1'b0;
        @(negedge clk);
        utrst = 1'b1;
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
